simple_cpu: RTL and testbench



---
 rtl/simple_cpu.sv | 181 ++++++++++++++++++
 tb/tb_simple_cpu.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit CPU: 32-bit PC, 8x8 register file, combinational ALU.
// Define BRANCH_JUMP_EN to enable the j (0x06) and beq (0x07) opcodes.
package simple_cpu_pkg;

  typedef enum logic [2:0] {
    ALU_IMM,
    ALU_MOV,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_t;

  typedef struct packed {
    logic [7:0] op;
    logic [2:0] dest;
    logic [7:0] off;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [7:0] imm;
  } dec_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    we;
    logic    jump;
    logic    branch;
  } ctl_t;

endpackage

module simple_cpu_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr_a,
  input  logic [2:0] raddr_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b
);

  logic [7:0] registers [0:7];

  // Reads see the pre-edge value; a same-cycle write lands next cycle.
  assign rdata_a = registers[raddr_a];
  assign rdata_b = registers[raddr_b];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        registers[i] <= 8'h00;
      end
    end else if (we) begin
      registers[waddr] <= wdata;
    end
  end

endmodule

module simple_cpu
  import simple_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION
);

  dec_t        d;
  ctl_t        ctl;
  logic [7:0]  rs1;
  logic [7:0]  rs2;
  logic [7:0]  alu_y;
  logic        alu_zero;
  logic [31:0] pc_seq;
  logic [31:0] pc_tgt;
  logic [31:0] pc_next;
  logic        take;
  logic        unused_bits;

  assign d.op   = INSTRUCTION[31:24];
  assign d.off  = INSTRUCTION[23:16];
  assign d.dest = INSTRUCTION[18:16];
  assign d.src1 = INSTRUCTION[10:8];
  assign d.src2 = INSTRUCTION[2:0];
  assign d.imm  = INSTRUCTION[7:0];

  assign unused_bits = ^INSTRUCTION[15:11];

  // Anything unrecognised (including X/Z) falls to the NOP default.
  always_comb begin
    ctl.alu_op = ALU_ADD;
    ctl.we     = 1'b0;
    ctl.jump   = 1'b0;
    ctl.branch = 1'b0;
    case (d.op)
      8'h00: begin
        ctl.alu_op = ALU_IMM;
        ctl.we     = 1'b1;
      end
      8'h01: begin
        ctl.alu_op = ALU_MOV;
        ctl.we     = 1'b1;
      end
      8'h02: begin
        ctl.alu_op = ALU_ADD;
        ctl.we     = 1'b1;
      end
      8'h03: begin
        ctl.alu_op = ALU_SUB;
        ctl.we     = 1'b1;
      end
      8'h04: begin
        ctl.alu_op = ALU_AND;
        ctl.we     = 1'b1;
      end
      8'h05: begin
        ctl.alu_op = ALU_OR;
        ctl.we     = 1'b1;
      end
`ifdef BRANCH_JUMP_EN
      8'h06: begin
        ctl.jump = 1'b1;
      end
      8'h07: begin
        ctl.alu_op = ALU_SUB;
        ctl.branch = 1'b1;
      end
`endif
      default: begin
        ctl.we = 1'b0;
      end
    endcase
  end

  simple_cpu_regfile register (
    .clk     (CLK),
    .rst_n   (RESET),
    .we      (ctl.we),
    .waddr   (d.dest),
    .wdata   (alu_y),
    .raddr_a (d.src1),
    .raddr_b (d.src2),
    .rdata_a (rs1),
    .rdata_b (rs2)
  );

  always_comb begin
    alu_y = 8'h00;
    unique case (ctl.alu_op)
      ALU_IMM: alu_y = d.imm;
      ALU_MOV: alu_y = rs2;
      ALU_ADD: alu_y = rs1 + rs2;
      ALU_SUB: alu_y = rs1 + (~rs2 + 8'd1);
      ALU_AND: alu_y = rs1 & rs2;
      ALU_OR:  alu_y = rs1 | rs2;
      default: alu_y = 8'h00;
    endcase
  end

  assign alu_zero = (alu_y == 8'h00);

  // Word offset, sign-extended and scaled to bytes.
  assign pc_seq  = PC + 32'd4;
  assign pc_tgt  = pc_seq + {{22{d.off[7]}}, d.off, 2'b00};
  assign take    = ctl.jump | (ctl.branch & alu_zero);
  assign pc_next = take ? pc_tgt : pc_seq;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      PC <= RESET_PC;
    end else begin
      PC <= pc_next;
    end
  end

endmodule

// File: tb/tb_simple_cpu.sv
// Testbench for simple_cpu: directed program steps plus random instructions
// checked against an architectural model of PC and the register file.
module tb_simple_cpu;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;

  int vectors;
  int miscompares;

  logic [7:0]  m_reg [8];
  logic [31:0] m_pc;
  logic [31:0] pc_prev;

  simple_cpu #(.RESET_PC(32'd0)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pc"}, PC, m_pc);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_r%0d", tag, i),
          {24'h0, dut.register.registers[i]}, {24'h0, m_reg[i]});
    end
  endtask

  function automatic void model_exec(input logic [31:0] ins);
    int a;
    int b;
    int soff;
    int dst;
    int op;
    bit jmp;
    op   = int'(ins[31:24]);
    dst  = int'(ins[18:16]);
    a    = int'(m_reg[ins[10:8]]);
    b    = int'(m_reg[ins[2:0]]);
    soff = int'($signed(ins[23:16]));
    jmp  = 1'b0;
    case (op)
      0: m_reg[dst] = ins[7:0];
      1: m_reg[dst] = 8'(b);
      2: m_reg[dst] = 8'((a + b) % 256);
      3: m_reg[dst] = 8'((a - b + 256) % 256);
      4: m_reg[dst] = 8'(a & b);
      5: m_reg[dst] = 8'(a | b);
`ifdef BRANCH_JUMP_EN
      6: jmp = 1'b1;
      7: jmp = (a == b);
`endif
      default: ;
    endcase
    if (jmp) m_pc = m_pc + 32'd4 + 32'(soff * 4);
    else     m_pc = m_pc + 32'd4;
  endfunction

  task automatic step(input logic [31:0] ins);
    INSTRUCTION = ins;
    model_exec(ins);
    @(posedge CLK);
    #1;
    check_state("step");
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0;
    INSTRUCTION = 32'h00000000 | $urandom();
    m_pc = 32'd0;
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    repeat (n) begin
      @(posedge CLK);
      #1;
      check_state("reset");
    end
    RESET = 1'b1;
  endtask

  function automatic logic [31:0] rand_ins();
    int unsigned sel;
    logic [31:0] r;
    logic [7:0] op;
    sel = $urandom_range(0, 9);
    r = $urandom();
    if (sel <= 7)      op = 8'(sel);
    else if (sel == 8) op = 8'hFF;
    else               op = 8'($urandom_range(8, 254));
    return {op, r[23:0]};
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    RESET = 1'b0;
    INSTRUCTION = 32'h0;

    // Reset then straight-line program
    do_reset(1);
    chk("tp1_pc0", PC, 32'd0);
    step(32'h00040005);
    chk("tp1_pc4", PC, 32'd4);
    step(32'h00020009);
    chk("tp1_pc8", PC, 32'd8);
    step(32'h02060402);
    chk("tp1_pc12", PC, 32'd12);
    chk("tp1_r4", {24'h0, dut.register.registers[4]}, 32'd5);
    chk("tp1_r2", {24'h0, dut.register.registers[2]}, 32'd9);
    chk("tp1_r6", {24'h0, dut.register.registers[6]}, 32'd14);

    // Reset mid-run held two edges, then restart
    do_reset(2);
    chk("midrst_pc", PC, 32'd0);
    chk("midrst_r6", {24'h0, dut.register.registers[6]}, 32'd0);
    step(32'h00030011);
    chk("restart_pc", PC, 32'd4);

    // Arithmetic wrap-around
    step(32'h000100FF);
    step(32'h00020002);
    step(32'h02030102);
    step(32'h03040201);
    chk("wrap_add", {24'h0, dut.register.registers[3]}, 32'h01);
    chk("wrap_sub", {24'h0, dut.register.registers[4]}, 32'h03);

    // Logic and move
    step(32'h000100F0);
    step(32'h0002003C);
    step(32'h04030102);
    step(32'h05050102);
    step(32'h01070005);
    chk("and_r3", {24'h0, dut.register.registers[3]}, 32'h30);
    chk("or_r5", {24'h0, dut.register.registers[5]}, 32'hFC);
    chk("mov_r7", {24'h0, dut.register.registers[7]}, 32'hFC);

    // Unknown opcode between loads
    step(32'h00000011);
    pc_prev = PC;
    step(32'hFF000000);
    chk("nop_pc", PC, pc_prev + 32'd4);
    chk("nop_r0", {24'h0, dut.register.registers[0]}, 32'h11);
    step(32'h00000022);

    // beq taken at PC=8
    do_reset(1);
    step(32'h00010007);
    step(32'h00020007);
    step(32'h07020102);
`ifdef BRANCH_JUMP_EN
    chk("beq_taken", PC, 32'd20);
`else
    chk("beq_taken", PC, 32'd12);
`endif

    // beq not taken at PC=8
    do_reset(1);
    step(32'h00010001);
    step(32'h00020002);
    step(32'h07020102);
    chk("beq_not", PC, 32'd12);

    // j -2 at PC=16
    do_reset(1);
    repeat (4) step(32'hFF000000);
    step(32'h06FE0000);
`ifdef BRANCH_JUMP_EN
    chk("j_back", PC, 32'd12);
`else
    chk("j_back", PC, 32'd20);
`endif

    // Backward jump from PC=0 wraps the 32-bit PC
    do_reset(1);
    step(32'h06FE0000);
`ifdef BRANCH_JUMP_EN
    chk("j_wrap", PC, 32'hFFFFFFFC);
`else
    chk("j_wrap", PC, 32'd4);
`endif
    step(32'hFF000000);

    // Random program with occasional resets
    do_reset(1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      else step(rand_ins());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
